// File: rtl/linebuf_scanout_if.sv
// Renderer write bus and pixel scan-out bus of the line buffer.
// master = renderer/video timing side, slave = line buffer.
interface linebuf_scanout_if #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 8
);
  logic [IDX_W-1:0]  linebuf_wridx;
  logic [DATA_W-1:0] linebuf_wrdata;
  logic              linebuf_wren;
  logic              pixel_en;
  logic [DATA_W-1:0] pix_idx;
  logic              pix_valid;

  modport master (
    output linebuf_wridx, linebuf_wrdata, linebuf_wren, pixel_en,
    input  pix_idx, pix_valid
  );

  modport slave (
    input  linebuf_wridx, linebuf_wrdata, linebuf_wren, pixel_en,
    output pix_idx, pix_valid
  );
endinterface

// File: rtl/linebuf_scanout.sv
// Double-buffered line buffer: renderer fills one bank while the other is scanned out.
// Optional LINEBUF_HSCALE_EN adds the hscale port (each stored pixel shown twice).
module linebuf_scanout #(
  parameter int WIDTH  = 640,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_of_line,
  input  logic status_clr,
`ifdef LINEBUF_HSCALE_EN
  input  logic hscale,
`endif
  linebuf_scanout_if.slave bus,
  output logic underrun_r
);

  // One extra bit so counters can hold WIDTH itself (the idle / full value).
  localparam int CW = IDX_W + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t WIDTH_C = cnt_t'(WIDTH);
  localparam cnt_t ONE_C   = cnt_t'(1);

  logic              wbank_q, wbank_d;
  cnt_t              wrcnt_q, wrcnt_d;
  cnt_t              rdx_q, rdx_d;
  logic              rd_ok_q, rd_ok_d;
  logic              hold_q, hold_d;
  logic              underrun_q, underrun_d;
  logic              pix_valid_q;
  logic              zero_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [2][WIDTH];

  logic scale_w;
`ifdef LINEBUF_HSCALE_EN
  assign scale_w = hscale;
`else
  assign scale_w = 1'b0;
`endif

  logic wr_accept, line_full, rd_bank, rd_in_range, rd_ok_now, hold_now, advance;
  cnt_t rd_addr;

  assign wr_accept = bus.linebuf_wren && ({1'b0, bus.linebuf_wridx} < WIDTH_C);
  // A write coinciding with start_of_line still counts toward completing the old line.
  assign line_full = (wrcnt_q == WIDTH_C) ||
                     (wr_accept && (wrcnt_q == WIDTH_C - ONE_C));

  // A read coinciding with start_of_line already targets the freshly completed bank at 0.
  assign rd_bank     = start_of_line ? wbank_q : ~wbank_q;
  assign rd_addr     = start_of_line ? '0 : rdx_q;
  assign rd_ok_now   = start_of_line ? line_full : rd_ok_q;
  assign hold_now    = start_of_line ? 1'b0 : hold_q;
  assign rd_in_range = rd_addr < WIDTH_C;
  assign advance     = !scale_w || hold_now;

  // NOTE: every always_comb output gets its default first, otherwise a missed branch infers a latch.
  always_comb begin
    wbank_d    = wbank_q;
    wrcnt_d    = wrcnt_q;
    rdx_d      = rdx_q;
    rd_ok_d    = rd_ok_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;

    if (wr_accept && (wrcnt_q != WIDTH_C)) begin
      wrcnt_d = wrcnt_q + ONE_C;
    end

    if (start_of_line) begin
      wbank_d = ~wbank_q;
      rd_ok_d = line_full;
      wrcnt_d = '0;
      rdx_d   = '0;
      hold_d  = 1'b0;
    end

    if (bus.pixel_en) begin
      if (scale_w) begin
        hold_d = ~hold_now;
      end
      if (advance && rd_in_range) begin
        rdx_d = rd_addr + ONE_C;
      end
    end

    if (start_of_line && !line_full) begin
      underrun_d = 1'b1;
    end else if (status_clr) begin
      underrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q     <= 1'b0;
      wrcnt_q     <= '0;
      rdx_q       <= WIDTH_C;
      rd_ok_q     <= 1'b0;
      hold_q      <= 1'b0;
      underrun_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      wbank_q     <= wbank_d;
      wrcnt_q     <= wrcnt_d;
      rdx_q       <= rdx_d;
      rd_ok_q     <= rd_ok_d;
      hold_q      <= hold_d;
      underrun_q  <= underrun_d;
      pix_valid_q <= bus.pixel_en;
      if (bus.pixel_en) begin
        zero_q <= !(rd_ok_now && rd_in_range);
      end
    end
  end

  // NOTE: the RAM and its read register are not reset so they map onto block RAM; zero_q masks stale data.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wbank_q][bus.linebuf_wridx] <= bus.linebuf_wrdata;
    end
    if (bus.pixel_en && rd_in_range) begin
      rd_data_q <= mem_q[rd_bank][rd_addr[IDX_W-1:0]];
    end
  end

  assign bus.pix_idx   = zero_q ? '0 : rd_data_q;
  assign bus.pix_valid = pix_valid_q;
  assign underrun_r    = underrun_q;

endmodule
